load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: DATA_LENGTH, 32, word width in bits.
REQ-002 Parameter: ADDR_LENGTH, 32, address width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  pipeline memory op present.
REQ-006 req_ready  output  1  unit accepts op this cycle.
REQ-007 req_store  input  1  0 = load, 1 = store.
REQ-008 req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-009 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 req_addr  input  ADDR_LENGTH  byte address.
REQ-011 req_wdata  input  DATA_LENGTH  store data, right-justified.
REQ-012 req_rd  input  5  destination tag, returned unchanged.
REQ-013 resp_valid  output  1  one-cycle completion pulse; no backpressure.
REQ-014 resp_data  output  DATA_LENGTH  extended load data; 0 for stores and exceptions.
REQ-015 resp_rd  output  5  tag of completing op.
REQ-016 resp_exc  output  1  misaligned or reserved-size exception.
REQ-017 resp_exc_addr  output  ADDR_LENGTH  faulting req_addr; 0 when resp_exc=0.
REQ-018 dc  dcache_interface.primary  --  cache port; drives addr, wdata, wmask, rw, valid; receives rdata, rvalid, ready.

Function
REQ-019 FSM states: IDLE, REQ, WAIT, RESP.
REQ-020 req_ready = 1 only in IDLE; an op is accepted on req_valid & req_ready, and all request fields are latched.
REQ-021 Accepted op misaligned (half with addr[0]=1; word with addr[1:0]!=0) or size 11: IDLE->RESP, no cache access, resp_exc=1.
REQ-022 Otherwise IDLE->REQ; dc.valid = 1 throughout REQ and 0 in every other state.
REQ-023 In REQ: dc.addr = {latched addr[ADDR_LENGTH-1:2], 2'b00}; dc.rw = latched store bit.
REQ-024 Store dc.wmask (bit-granular): byte 0x000000FF << 8*addr[1:0]; half 0x0000FFFF << 8*addr[1:0]; word 0xFFFFFFFF. Loads drive wmask = 0.
REQ-025 Store dc.wdata: byte replicated into all 4 lanes; half replicated into both halves; word unchanged. Loads drive wdata = 0.
REQ-026 All dc outputs hold stable in REQ until dc.ready = 1.
REQ-027 Handshake (REQ & dc.ready): store -> RESP; load -> WAIT, or directly -> RESP if dc.rvalid is also 1 in the same cycle.
REQ-028 In WAIT, dc.rvalid = 1 -> capture data and go to RESP; otherwise stay in WAIT indefinitely. dc.rvalid is ignored in IDLE and RESP.
REQ-029 Load extraction: select the lane by latched addr[1:0] (byte) or addr[1] (half), then zero- or sign-extend per req_unsigned; word is passed through.
REQ-030 RESP lasts exactly one cycle: resp_valid = 1, resp_data/resp_rd/resp_exc/resp_exc_addr valid, then IDLE.
REQ-031 Latency: accept at cycle N, dc.valid at N+1; with ready and rvalid at N+1, resp_valid at N+2. Exception: resp_valid at N+1.
REQ-032 Response outputs are registered and equal 0 outside RESP.
REQ-033 Ops back-to-back: the minimum spacing between accepts is 3 cycles for a cache access and 2 for an exception.

Reset
REQ-034 rst_n = 0 immediately forces state IDLE and all outputs to 0 (req_ready = 0), independent of clk.
REQ-035 Reset mid-transaction abandons the op with no response; any later dc.rvalid is ignored.
REQ-036 After rst_n deasserts, req_ready = 1 on the first clk edge at which the state is IDLE.

Verification
REQ-037 Store byte: addr 0x1003, wdata 0x000000AB -> dc.addr 0x1000, wmask 0xFF000000, wdata 0xABABABAB, rw=1; resp_valid with resp_data 0.
REQ-038 Load half signed: addr 0x2002, rdata 0x8001_1234 -> resp_data 0xFFFF8001; same with unsigned -> 0x00008001.
REQ-039 Misaligned word load: addr 0x3001 -> no dc.valid; next cycle resp_exc=1, resp_exc_addr 0x3001, resp_data 0.
REQ-040 dc.ready low 5 cycles, then rvalid 3 cycles later -> dc outputs stable throughout REQ; exactly one resp_valid pulse.
REQ-041 Load with ready and rvalid in the same cycle -> resp_valid on the following cycle; WAIT is skipped.
REQ-042 Reset asserted in WAIT, then a stray rvalid -> no resp_valid; outputs 0; req_ready = 1 after release.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Data-cache port shared between the load/store unit (primary) and the cache (secondary).
//   addr/wdata/wmask/rw/valid : request from the unit, word-aligned address, bit-granular mask
//   rdata/rvalid/ready        : cache accepts a request on ready, returns load data on rvalid
interface dcache_interface #(
    parameter int unsigned DATA_LENGTH = 32,
    parameter int unsigned ADDR_LENGTH = 32
);
    logic [ADDR_LENGTH-1:0] addr;
    logic [DATA_LENGTH-1:0] wdata;
    logic [DATA_LENGTH-1:0] wmask;
    logic                   rw;
    logic                   valid;
    logic [DATA_LENGTH-1:0] rdata;
    logic                   rvalid;
    logic                   ready;

    modport primary (
        output addr, wdata, wmask, rw, valid,
        input  rdata, rvalid, ready
    );

    modport secondary (
        input  addr, wdata, wmask, rw, valid,
        output rdata, rvalid, ready
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one pipeline memory op at a time, checks alignment,
// issues a single data-cache access and returns one registered response pulse.
//   req_*  : op from the pipeline, accepted on req_valid & req_ready
//   resp_* : one-cycle completion (load data extended, or exception with faulting address)
//   dc     : data-cache port, all outputs registered and held stable while waiting for ready
module load_store_unit #(
    parameter int unsigned DATA_LENGTH = 32,
    parameter int unsigned ADDR_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_store,
    input  logic [1:0]             req_size,
    input  logic                   req_unsigned,
    input  logic [ADDR_LENGTH-1:0] req_addr,
    input  logic [DATA_LENGTH-1:0] req_wdata,
    input  logic [4:0]             req_rd,
    output logic                   resp_valid,
    output logic [DATA_LENGTH-1:0] resp_data,
    output logic [4:0]             resp_rd,
    output logic                   resp_exc,
    output logic [ADDR_LENGTH-1:0] resp_exc_addr,
    dcache_interface.primary       dc
);
    localparam logic [DATA_LENGTH-1:0] BYTE_MASK = DATA_LENGTH'(8'hFF);
    localparam logic [DATA_LENGTH-1:0] HALF_MASK = DATA_LENGTH'(16'hFFFF);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t                 state_q, state_d;
    logic                   req_ready_q, req_ready_d;
    logic                   store_q, store_d;
    logic [1:0]             size_q, size_d;
    logic                   uns_q, uns_d;
    logic [1:0]             off_q, off_d;
    logic [4:0]             rd_q, rd_d;
    logic                   dc_valid_q, dc_valid_d;
    logic                   dc_rw_q, dc_rw_d;
    logic [ADDR_LENGTH-1:0] dc_addr_q, dc_addr_d;
    logic [DATA_LENGTH-1:0] dc_wmask_q, dc_wmask_d;
    logic [DATA_LENGTH-1:0] dc_wdata_q, dc_wdata_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [DATA_LENGTH-1:0] resp_data_q, resp_data_d;
    logic [4:0]             resp_rd_q, resp_rd_d;
    logic                   resp_exc_q, resp_exc_d;
    logic [ADDR_LENGTH-1:0] resp_exc_addr_q, resp_exc_addr_d;

    logic                   misaligned_c;
    logic [DATA_LENGTH-1:0] store_mask_c;
    logic [DATA_LENGTH-1:0] store_data_c;
    logic [7:0]             lane_byte_c;
    logic [15:0]            lane_half_c;
    logic [DATA_LENGTH-1:0] load_data_c;

    // Alignment check and store lane formatting, evaluated on the incoming request.
    always_comb begin
        misaligned_c = (req_size == 2'b11)
                     || ((req_size == 2'b01) && req_addr[0])
                     || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
        case (req_size)
            2'b00: begin
                store_mask_c = BYTE_MASK << {req_addr[1:0], 3'b000};
                store_data_c = {(DATA_LENGTH/8){req_wdata[7:0]}};
            end
            2'b01: begin
                store_mask_c = HALF_MASK << {req_addr[1:0], 3'b000};
                store_data_c = {(DATA_LENGTH/16){req_wdata[15:0]}};
            end
            default: begin
                store_mask_c = '1;
                store_data_c = req_wdata;
            end
        endcase
    end

    // Load lane selection and extension from the returned cache word.
    always_comb begin
        lane_byte_c = 8'(dc.rdata >> {off_q, 3'b000});
        lane_half_c = 16'(dc.rdata >> {off_q[1], 4'b0000});
        case (size_q)
            2'b00:   load_data_c = uns_q ? DATA_LENGTH'(lane_byte_c)
                                         : {{(DATA_LENGTH-8){lane_byte_c[7]}}, lane_byte_c};
            2'b01:   load_data_c = uns_q ? DATA_LENGTH'(lane_half_c)
                                         : {{(DATA_LENGTH-16){lane_half_c[15]}}, lane_half_c};
            default: load_data_c = dc.rdata;
        endcase
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d         = state_q;
        store_d         = store_q;
        size_d          = size_q;
        uns_d           = uns_q;
        off_d           = off_q;
        rd_d            = rd_q;
        dc_valid_d      = 1'b0;
        dc_rw_d         = 1'b0;
        dc_addr_d       = '0;
        dc_wmask_d      = '0;
        dc_wdata_d      = '0;
        resp_valid_d    = 1'b0;
        resp_data_d     = '0;
        resp_rd_d       = '0;
        resp_exc_d      = 1'b0;
        resp_exc_addr_d = '0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    store_d = req_store;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    off_d   = req_addr[1:0];
                    rd_d    = req_rd;
                    if (misaligned_c) begin
                        state_d         = RESP;
                        resp_valid_d    = 1'b1;
                        resp_exc_d      = 1'b1;
                        resp_exc_addr_d = req_addr;
                        resp_rd_d       = req_rd;
                    end else begin
                        state_d    = REQ;
                        dc_valid_d = 1'b1;
                        dc_rw_d    = req_store;
                        dc_addr_d  = {req_addr[ADDR_LENGTH-1:2], 2'b00};
                        if (req_store) begin
                            dc_wmask_d = store_mask_c;
                            dc_wdata_d = store_data_c;
                        end
                    end
                end
            end
            REQ: begin
                if (dc.ready) begin
                    if (store_q) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_rd_d    = rd_q;
                    end else if (dc.rvalid) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_rd_d    = rd_q;
                        resp_data_d  = load_data_c;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    // Request held unchanged until the cache takes it.
                    dc_valid_d = 1'b1;
                    dc_rw_d    = dc_rw_q;
                    dc_addr_d  = dc_addr_q;
                    dc_wmask_d = dc_wmask_q;
                    dc_wdata_d = dc_wdata_q;
                end
            end
            WAIT: begin
                if (dc.rvalid) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rd_d    = rd_q;
                    resp_data_d  = load_data_c;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            req_ready_q     <= 1'b0;
            store_q         <= 1'b0;
            size_q          <= 2'b00;
            uns_q           <= 1'b0;
            off_q           <= 2'b00;
            rd_q            <= '0;
            dc_valid_q      <= 1'b0;
            dc_rw_q         <= 1'b0;
            dc_addr_q       <= '0;
            dc_wmask_q      <= '0;
            dc_wdata_q      <= '0;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            resp_rd_q       <= '0;
            resp_exc_q      <= 1'b0;
            resp_exc_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            req_ready_q     <= req_ready_d;
            store_q         <= store_d;
            size_q          <= size_d;
            uns_q           <= uns_d;
            off_q           <= off_d;
            rd_q            <= rd_d;
            dc_valid_q      <= dc_valid_d;
            dc_rw_q         <= dc_rw_d;
            dc_addr_q       <= dc_addr_d;
            dc_wmask_q      <= dc_wmask_d;
            dc_wdata_q      <= dc_wdata_d;
            resp_valid_q    <= resp_valid_d;
            resp_data_q     <= resp_data_d;
            resp_rd_q       <= resp_rd_d;
            resp_exc_q      <= resp_exc_d;
            resp_exc_addr_q <= resp_exc_addr_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_data     = resp_data_q;
    assign resp_rd       = resp_rd_q;
    assign resp_exc      = resp_exc_q;
    assign resp_exc_addr = resp_exc_addr_q;
    assign dc.valid      = dc_valid_q;
    assign dc.rw         = dc_rw_q;
    assign dc.addr       = dc_addr_q;
    assign dc.wmask      = dc_wmask_q;
    assign dc.wdata      = dc_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a hand-driven cache port.
module tb_load_store_unit;
    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_exc;
    logic [31:0] resp_exc_addr;

    int n_checks = 0;
    int n_fail   = 0;

    dcache_interface #(.DATA_LENGTH(32), .ADDR_LENGTH(32)) dc_if ();

    load_store_unit #(.DATA_LENGTH(32), .ADDR_LENGTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_store     (req_store),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_rd        (req_rd),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .resp_rd       (resp_rd),
        .resp_exc      (resp_exc),
        .resp_exc_addr (resp_exc_addr),
        .dc            (dc_if.primary)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic st, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        req_valid    = 1'b1;
        req_store    = st;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        req_rd       = rd;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; req_rd = '0;
        dc_if.rdata = '0; dc_if.rvalid = 1'b0; dc_if.ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %h expected 0", req_ready); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %h expected 0", resp_valid); end
        n_checks++; if (dc_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_dc_valid: got %h expected 0", dc_if.valid); end
        n_checks++; if ({resp_data, resp_exc_addr} !== 64'h0) begin n_fail++; $display("FAIL reset_resp_bus: got %h expected 0", {resp_data, resp_exc_addr}); end
        tick(); tick();
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_held_ready: got %h expected 0", req_ready); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %h expected 1", req_ready); end
    endtask

    task automatic test_store_byte();
        dc_if.ready = 1'b0;
        set_req(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00AB, 5'd7);
        tick();
        req_valid = 1'b0;
        n_checks++; if (dc_if.valid !== 1'b1) begin n_fail++; $display("FAIL sb_dc_valid: got %h expected 1", dc_if.valid); end
        n_checks++; if (dc_if.addr !== 32'h0000_1000) begin n_fail++; $display("FAIL sb_dc_addr: got %h expected 00001000", dc_if.addr); end
        n_checks++; if (dc_if.wmask !== 32'hFF00_0000) begin n_fail++; $display("FAIL sb_wmask: got %h expected ff000000", dc_if.wmask); end
        n_checks++; if (dc_if.wdata !== 32'hABAB_ABAB) begin n_fail++; $display("FAIL sb_wdata: got %h expected abababab", dc_if.wdata); end
        n_checks++; if (dc_if.rw !== 1'b1) begin n_fail++; $display("FAIL sb_rw: got %h expected 1", dc_if.rw); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL sb_busy_ready: got %h expected 0", req_ready); end
        dc_if.ready = 1'b1;
        tick();
        dc_if.ready = 1'b0;
        n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL sb_resp_valid: got %h expected 1", resp_valid); end
        n_checks++; if (resp_data !== 32'h0) begin n_fail++; $display("FAIL sb_resp_data: got %h expected 0", resp_data); end
        n_checks++; if (resp_rd !== 5'd7) begin n_fail++; $display("FAIL sb_resp_rd: got %0d expected 7", resp_rd); end
        n_checks++; if (dc_if.valid !== 1'b0) begin n_fail++; $display("FAIL sb_dc_valid_drop: got %h expected 0", dc_if.valid); end
        tick();
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL sb_resp_one_cycle: got %h expected 0", resp_valid); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL sb_ready_back: got %h expected 1", req_ready); end
    endtask

    task automatic test_store_half_word();
        dc_if.ready = 1'b1;
        set_req(1'b1, 2'b01, 1'b0, 32'h0000_1102, 32'h1234_5678, 5'd2);
        tick();
        req_valid = 1'b0;
        n_checks++; if (dc_if.wmask !== 32'hFFFF_0000) begin n_fail++; $display("FAIL sh_wmask: got %h expected ffff0000", dc_if.wmask); end
        n_checks++; if (dc_if.wdata !== 32'h5678_5678) begin n_fail++; $display("FAIL sh_wdata: got %h expected 56785678", dc_if.wdata); end
        tick(); tick();
        set_req(1'b1, 2'b10, 1'b0, 32'h0000_1204, 32'hCAFE_F00D, 5'd3);
        tick();
        req_valid = 1'b0;
        n_checks++; if (dc_if.wmask !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sw_wmask: got %h expected ffffffff", dc_if.wmask); end
        n_checks++; if (dc_if.wdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL sw_wdata: got %h expected cafef00d", dc_if.wdata); end
        n_checks++; if (dc_if.addr !== 32'h0000_1204) begin n_fail++; $display("FAIL sw_addr: got %h expected 00001204", dc_if.addr); end
        tick(); tick();
        dc_if.ready = 1'b0;
    endtask

    // Ready and rvalid together in REQ: the response follows the next edge, WAIT is skipped.
    task automatic test_load_half();
        dc_if.ready = 1'b1; dc_if.rvalid = 1'b1; dc_if.rdata = 32'h8001_1234;
        set_req(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'hFFFF_FFFF, 5'd9);
        tick();
        req_valid = 1'b0;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL lh_idle_rvalid_ignored: got %h expected 0", resp_valid); end
        n_checks++; if (dc_if.addr !== 32'h0000_2000) begin n_fail++; $display("FAIL lh_addr: got %h expected 00002000", dc_if.addr); end
        n_checks++; if ({dc_if.wmask, dc_if.wdata} !== 64'h0) begin n_fail++; $display("FAIL lh_load_wmask_wdata: got %h expected 0", {dc_if.wmask, dc_if.wdata}); end
        n_checks++; if (dc_if.rw !== 1'b0) begin n_fail++; $display("FAIL lh_rw: got %h expected 0", dc_if.rw); end
        tick();
        n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL lh_resp_valid: got %h expected 1", resp_valid); end
        n_checks++; if (resp_data !== 32'hFFFF_8001) begin n_fail++; $display("FAIL lh_signed: got %h expected ffff8001", resp_data); end
        n_checks++; if (resp_rd !== 5'd9) begin n_fail++; $display("FAIL lh_rd: got %0d expected 9", resp_rd); end
        tick();
        set_req(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 5'd10);
        tick();
        req_valid = 1'b0;
        tick();
        n_checks++; if (resp_data !== 32'h0000_8001) begin n_fail++; $display("FAIL lh_unsigned: got %h expected 00008001", resp_data); end
        tick();
        set_req(1'b0, 2'b00, 1'b0, 32'h0000_2001, 32'h0, 5'd11);
        tick();
        req_valid = 1'b0;
        tick();
        n_checks++; if (resp_data !== 32'h0000_0012) begin n_fail++; $display("FAIL lb_lane1: got %h expected 00000012", resp_data); end
        tick();
        set_req(1'b0, 2'b00, 1'b0, 32'h0000_2003, 32'h0, 5'd12);
        tick();
        req_valid = 1'b0;
        tick();
        n_checks++; if (resp_data !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_lane3_signed: got %h expected ffffff80", resp_data); end
        tick();
        dc_if.ready = 1'b0; dc_if.rvalid = 1'b0;
    endtask

    task automatic test_misaligned();
        dc_if.ready = 1'b1;
        set_req(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 5'd4);
        tick();
        req_valid = 1'b0;
        n_checks++; if (dc_if.valid !== 1'b0) begin n_fail++; $display("FAIL mis_no_dc_valid: got %h expected 0", dc_if.valid); end
        n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL mis_resp_valid: got %h expected 1", resp_valid); end
        n_checks++; if (resp_exc !== 1'b1) begin n_fail++; $display("FAIL mis_exc: got %h expected 1", resp_exc); end
        n_checks++; if (resp_exc_addr !== 32'h0000_3001) begin n_fail++; $display("FAIL mis_exc_addr: got %h expected 00003001", resp_exc_addr); end
        n_checks++; if (resp_data !== 32'h0) begin n_fail++; $display("FAIL mis_data: got %h expected 0", resp_data); end
        n_checks++; if (resp_rd !== 5'd4) begin n_fail++; $display("FAIL mis_rd: got %0d expected 4", resp_rd); end
        tick();
        n_checks++; if ({resp_valid, resp_exc, resp_exc_addr} !== 34'h0) begin n_fail++; $display("FAIL mis_clear: got %h expected 0", {resp_valid, resp_exc, resp_exc_addr}); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mis_ready: got %h expected 1", req_ready); end
        set_req(1'b1, 2'b11, 1'b0, 32'h0000_4000, 32'h0, 5'd5);
        tick();
        req_valid = 1'b0;
        n_checks++; if (resp_exc !== 1'b1 || dc_if.valid !== 1'b0) begin n_fail++; $display("FAIL rsv_size_exc: got exc=%h dc_valid=%h expected exc=1 dc_valid=0", resp_exc, dc_if.valid); end
        tick();
        set_req(1'b0, 2'b01, 1'b0, 32'h0000_4003, 32'h0, 5'd6);
        tick();
        req_valid = 1'b0;
        n_checks++; if (resp_exc !== 1'b1 || resp_exc_addr !== 32'h0000_4003) begin n_fail++; $display("FAIL mis_half: got exc=%h addr=%h expected exc=1 addr=00004003", resp_exc, resp_exc_addr); end
        tick();
        dc_if.ready = 1'b0;
    endtask

    // Ready low for 5 cycles, then a WAIT with rvalid on its third cycle.
    task automatic test_stall();
        int pulses;
        int unstable;
        pulses = 0; unstable = 0;
        dc_if.ready = 1'b0; dc_if.rvalid = 1'b0; dc_if.rdata = 32'hDEAD_BEEF;
        set_req(1'b0, 2'b10, 1'b0, 32'h0000_5004, 32'h0, 5'd13);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (dc_if.valid !== 1'b1 || dc_if.addr !== 32'h0000_5004 || dc_if.rw !== 1'b0 || dc_if.wmask !== 32'h0) unstable++;
            if (resp_valid === 1'b1) pulses++;
            tick();
        end
        n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL stall_dc_stable: got %0d unstable cycles expected 0", unstable); end
        n_checks++; if (dc_if.valid !== 1'b1) begin n_fail++; $display("FAIL stall_still_req: got %h expected 1", dc_if.valid); end
        dc_if.ready = 1'b1;
        tick();
        dc_if.ready = 1'b0;
        n_checks++; if (dc_if.valid !== 1'b0) begin n_fail++; $display("FAIL stall_wait_dc_valid: got %h expected 0", dc_if.valid); end
        for (int i = 0; i < 2; i++) begin
            if (resp_valid === 1'b1) pulses++;
            tick();
        end
        dc_if.rvalid = 1'b1;
        tick();
        dc_if.rvalid = 1'b0;
        n_checks++; if (resp_data !== 32'hDEAD_BEEF || resp_valid !== 1'b1) begin n_fail++; $display("FAIL stall_resp: got valid=%h data=%h expected valid=1 data=deadbeef", resp_valid, resp_data); end
        for (int i = 0; i < 4; i++) begin
            if (resp_valid === 1'b1) pulses++;
            tick();
        end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL stall_one_pulse: got %0d pulses expected 1", pulses); end
    endtask

    task automatic test_reset_in_wait();
        int pulses;
        pulses = 0;
        dc_if.ready = 1'b1; dc_if.rvalid = 1'b0; dc_if.rdata = 32'h1111_2222;
        set_req(1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0, 5'd14);
        tick();
        req_valid = 1'b0;
        tick();
        dc_if.ready = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({req_ready, resp_valid, dc_if.valid, resp_rd} !== 8'h0) begin n_fail++; $display("FAIL rst_wait_async_clear: got %h expected 0", {req_ready, resp_valid, dc_if.valid, resp_rd}); end
        tick();
        rst_n = 1'b1;
        dc_if.rvalid = 1'b1;
        tick();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wait_ready: got %h expected 1", req_ready); end
        for (int i = 0; i < 3; i++) begin
            if (resp_valid === 1'b1) pulses++;
            tick();
        end
        dc_if.rvalid = 1'b0;
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL rst_wait_stray_rvalid: got %0d pulses expected 0", pulses); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] seen;
        seen = '0;
        dc_if.ready = 1'b1; dc_if.rvalid = 1'b1; dc_if.rdata = 32'h0000_0042;
        set_req(1'b0, 2'b10, 1'b0, 32'h0000_7000, 32'h0, 5'd15);
        for (int i = 5; i >= 0; i--) begin
            tick();
            seen[i] = resp_valid;
        end
        req_valid = 1'b0;
        tick();
        n_checks++; if (seen !== 6'b010_010) begin n_fail++; $display("FAIL b2b_cache_spacing: got %b expected 010010", seen); end
        seen = '0;
        set_req(1'b0, 2'b01, 1'b0, 32'h0000_7001, 32'h0, 5'd16);
        for (int i = 5; i >= 0; i--) begin
            tick();
            seen[i] = resp_valid;
        end
        req_valid = 1'b0;
        tick();
        n_checks++; if (seen !== 6'b101_010) begin n_fail++; $display("FAIL b2b_exc_spacing: got %b expected 101010", seen); end
        dc_if.ready = 1'b0; dc_if.rvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_store_half_word();
        test_load_half();
        test_misaligned();
        test_stall();
        test_reset_in_wait();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
